// File: rtl/hc595_pkg.sv
// Shared types and defaults for the 74HC595-style serial driver.
// Used by hc595_serial_driver and hc595_phase_timer.
package hc595_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SH_LO     = 3'd1,
    S_SH_HI     = 3'd2,
    S_LATCH     = 3'd3,
    S_CLR_MR    = 3'd4,
    S_CLR_LATCH = 3'd5
  } state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned PWM_CNT_W   = 8;

endpackage

// File: rtl/hc595_phase_timer.sv
// Loadable down-counter: after a load, done_o pulses for one cycle once
// CLK_DIV cycles (counting the load cycle's successor onward) have elapsed.
module hc595_phase_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_bar_i,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [TW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // next-state: reload wins over counting so back-to-back phases chain cleanly
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load_i) begin
      cnt_d   = TW'(CLK_DIV - 1);
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == {TW{1'b0}}) begin
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q - TW'(1);
      end
    end else begin
      armed_d = 1'b0;
    end
  end

  // counter and armed flag
  always_ff @(posedge clk_i or negedge rst_bar_i) begin
    if (!rst_bar_i) begin
      cnt_q   <= {TW{1'b0}};
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign done_o = armed_q && (cnt_q == {TW{1'b0}});

endmodule

// File: rtl/hc595_serial_driver.sv
// Serializes parallel words MSB-first into a 74HC595-style register.
// Optional OE_PWM_EN adds a DUTY port and PWM-modulated OE_BAR.
module hc595_serial_driver
  import hc595_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic             CLK,
  input  logic             RST_BAR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  input  logic             CLR,
  output logic             BUSY,
  output logic             DS,
  output logic             SHCP,
  output logic             STCP,
  output logic             MR_BAR,
  output logic             OE_BAR
`ifdef OE_PWM_EN
  ,
  input  logic [PWM_CNT_W-1:0] DUTY
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             latched_q, latched_d;
  logic             ds_q, shcp_q, stcp_q, mr_bar_q, oe_bar_q;
  logic             oe_bar_d;
  logic             phase_load_s, phase_done_s;

  // Every state change restarts the phase timer, so each state lasts CLK_DIV cycles.
  assign phase_load_s = (state_d != state_q);

  hc595_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk_i     (CLK),
    .rst_bar_i (RST_BAR),
    .load_i    (phase_load_s),
    .done_o    (phase_done_s)
  );

  // FSM next-state; ready_q lags IDLE by one cycle, so IDLE only acts once ready is visible
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    latched_d = latched_q;
    ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (ready_q && CLR) begin
          state_d = S_CLR_MR;
          ready_d = 1'b0;
        end else if (ready_q && DIN_VALID) begin
          sreg_d  = DIN;
          cnt_d   = CW'(WIDTH);
          state_d = S_SH_LO;
          ready_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SH_LO: begin
        if (phase_done_s) begin
          state_d = S_SH_HI;
        end else begin
          state_d = S_SH_LO;
        end
      end
      S_SH_HI: begin
        if (phase_done_s) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q != CW'(1)) begin
            sreg_d  = sreg_q << 1;
            state_d = S_SH_LO;
          end else begin
            state_d = S_LATCH;
          end
        end else begin
          state_d = S_SH_HI;
        end
      end
      S_LATCH, S_CLR_LATCH: begin
        if (phase_done_s) begin
          latched_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_CLR_MR: begin
        if (phase_done_s) begin
          state_d = S_CLR_LATCH;
        end else begin
          state_d = S_CLR_MR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, data and bookkeeping registers
  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state_q   <= S_IDLE;
      sreg_q    <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      ready_q   <= 1'b0;
      latched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      latched_q <= latched_d;
    end
  end

`ifdef OE_PWM_EN
  logic [PWM_CNT_W-1:0] pwm_cnt_q;

  // free-running brightness counter, wraps 255 -> 0
  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      pwm_cnt_q <= {PWM_CNT_W{1'b0}};
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_CNT_W'(1);
    end
  end

  assign oe_bar_d = latched_q ? !(pwm_cnt_q < DUTY) : 1'b1;
`else
  assign oe_bar_d = ~latched_q;
`endif

  // Pin drivers follow the state one cycle late; DS moves with SHCP falling, never rising.
  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      ds_q     <= 1'b0;
      shcp_q   <= 1'b0;
      stcp_q   <= 1'b0;
      mr_bar_q <= 1'b1;
      oe_bar_q <= 1'b1;
    end else begin
      ds_q     <= sreg_q[WIDTH-1];
      shcp_q   <= (state_q == S_SH_HI);
      stcp_q   <= (state_q == S_LATCH) || (state_q == S_CLR_LATCH);
      mr_bar_q <= (state_q != S_CLR_MR);
      oe_bar_q <= oe_bar_d;
    end
  end

  assign DIN_READY = ready_q;
  assign BUSY      = ~ready_q;
  assign DS        = ds_q;
  assign SHCP      = shcp_q;
  assign STCP      = stcp_q;
  assign MR_BAR    = mr_bar_q;
  assign OE_BAR    = oe_bar_q;

endmodule

// File: doc/hc595_serial_driver.md
# hc595_serial_driver

Upstream driver for the 8-bit serial-in / serial-or-parallel-out shift register stage. It accepts a parallel word over a valid/ready handshake and serializes it MSB-first onto DS, generating SHCP shift clocks and a single STCP latch pulse, all derived from one system clock. It also drives MR_BAR for clear requests and OE_BAR for output enable, so the register's Q[7:0] mirrors each accepted word.

## Interface
- WIDTH, 8: bits per transfer; must be ≥ 1.
- CLK_DIV, 4: system-clock cycles per SHCP/STCP half-phase; must be ≥ 1.

- CLK  input  1  system clock; all logic is rising-edge.
- RST_BAR  input  1  reset, asynchronous, active-low.
- DIN  input  WIDTH  parallel word to send.
- DIN_VALID  input  1  DIN holds a word to send.
- DIN_READY  output  1  driver accepts DIN on this cycle.
- CLR  input  1  clear request; sampled only in IDLE.
- BUSY  output  1  equals !DIN_READY.
- DS  output  1  serial data to the shift register.
- SHCP  output  1  shift clock.
- STCP  output  1  storage (latch) clock.
- MR_BAR  output  1  master reset to the shift register, active-low.
- OE_BAR  output  1  output enable, active-low.
- DUTY  input  8  brightness duty; present only with OE_PWM_EN.

## Operation
- Reset values: DS=0, SHCP=0, STCP=0, MR_BAR=1, OE_BAR=1, DIN_READY=0 while RST_BAR=0, and DIN_READY=1 on the first cycle after release. Internal shift register, counters and the "latched-once" flag all clear to 0.
- States: IDLE, SH_LO, SH_HI, LATCH, CLR_MR, CLR_LATCH.
- IDLE: DIN_READY=1.
  - CLR=1 has priority: go to CLR_MR and ignore DIN_VALID that cycle.
  - Otherwise DIN_VALID=1: capture DIN, set DS=DIN[WIDTH-1], load bit count = WIDTH, go to SH_LO.
- SH_LO: SHCP=0 and DS holds the current bit for CLK_DIV cycles, then go to SH_HI.
- SH_HI: SHCP=1 for CLK_DIV cycles, then decrement the bit count.
  - Count not 0: shift left, DS = next bit, go to SH_LO.
  - Count 0: go to LATCH.
- LATCH: SHCP=0, STCP=1 for CLK_DIV cycles; set latched-once; go to IDLE with STCP=0.
- CLR_MR: MR_BAR=0 for CLK_DIV cycles, then go to CLR_LATCH.
- CLR_LATCH: MR_BAR=1, STCP=1 for CLK_DIV cycles; set latched-once; go to IDLE.
- DS changes only in cycles where SHCP is 0 or going low, never on a SHCP rising edge.
- CLR and DIN_VALID outside IDLE are ignored. DIN need not be held after acceptance.
- Reset mid-transfer: outputs return to reset values immediately and the partial word is discarded. The shift register keeps stale contents until the next full transfer.

## Timing
- Acceptance edge is T0. SHCP rising edges occur at T0 + (2k+1)·CLK_DIV + 1 for k = 0..WIDTH-1.
- STCP is high for cycles T0 + 2·WIDTH·CLK_DIV + 1 through T0 + (2·WIDTH+1)·CLK_DIV.
- DIN_READY returns at T0 + (2·WIDTH+1)·CLK_DIV + 1. This is 35 cycles for WIDTH=8, CLK_DIV=2.
- A clear takes 2·CLK_DIV cycles plus one IDLE cycle.
- Back-to-back: a word held valid is accepted on the first IDLE cycle, so there is exactly one IDLE cycle between transfers.

## Configuration
- OE_PWM_EN defined:
  - DUTY port exists and a free-running 8-bit counter wraps 255→0.
  - After latched-once, OE_BAR = !(cnt < DUTY). DUTY=0 keeps outputs off; DUTY=255 drives 255/256 on.
- OE_PWM_EN undefined: no DUTY port or counter. OE_BAR=1 until latched-once, then constant 0.
- In both builds OE_BAR=1 before the first latch, so power-up garbage is never shown.

## Structure
- Package hc595_pkg holds the state enum, default WIDTH/CLK_DIV, and the PWM counter width (8).
- One sub-module, hc595_phase_timer: loadable down-counter emitting a one-cycle done pulse after CLK_DIV cycles. The FSM reloads it on every state entry.

## Test plan
Bench instantiates the existing shift-register block as a model on DS/SHCP/STCP/MR_BAR/OE_BAR, with WIDTH=8 and CLK_DIV=2.
- Send 0xA5 → DS sampled on SHCP rises reads 1,0,1,0,0,1,0,1; one STCP pulse; model Q=0xA5; DIN_READY back exactly 35 cycles after acceptance.
- 0x3C then 0xFF held valid back-to-back → one IDLE cycle between; Q=0x3C then Q=0xFF; 16 SHCP rises total.
- After Q=0xFF, pulse CLR in IDLE → MR_BAR low for 2 cycles, STCP pulse, Q=0x00. Assert CLR with DIN_VALID=1 together → clear wins, then the word is sent.
- Drop RST_BAR after the 3rd SHCP rise → all outputs at reset values asynchronously. After release, send 0x81 → Q=0x81.
- OE_PWM_EN with DUTY=64 → OE_BAR low 64 of every 256 cycles after first latch. DUTY=0 → OE_BAR always 1. Without the macro → OE_BAR=1 before first latch, 0 after.
